mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Data-memory access controller between the CPU datapath and a multi-cycle memory.
- Accepts one read or write from the CPU, drives a req/ack handshake to memory, and returns read data.
- Publishes a 3-bit status code consumed by the CPU freeze logic:
  - 000 = FREE; the pipeline may advance.
  - 111 = STALL; the pipeline must hold.
  - Any other code means the freeze logic keeps its previous decision.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, maximum WAIT cycles before abort. Only used with MEMCTL_TIMEOUT_EN.
- CNT_W, 8, timeout counter width. Must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  CPU read request.
- wr_en  in  1  CPU write request.
- addr  in  ADDR_W  CPU address.
- wdata  in  DATA_W  CPU write data.
- rdata  out  DATA_W  read data, registered.
- rdata_valid  out  1  one-cycle pulse when rdata is updated.
- state  out  3  status code to the freeze logic: 000 FREE, 111 STALL, 101 ERR.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - state=000, mem_req=0, mem_we=0, rdata_valid=0.
  - rdata, mem_addr, mem_wdata and the timeout counter clear to 0.
- FSM states: IDLE, WAIT, DONE, ERR. All outputs are Moore outputs, registered, with no combinational path from inputs.
- IDLE (state=000):
  - If rd_en or wr_en is high at a rising edge, latch addr, wdata and we into mem_addr, mem_wdata and mem_we, then go to WAIT.
  - wr_en has priority when both are asserted: the access is a write.
  - Otherwise remain in IDLE.
- WAIT (state=111, mem_req=1):
  - On mem_ack=1, capture mem_rdata into rdata (reads only) and go to DONE.
  - mem_req drops in the cycle after ack is sampled.
  - Minimum latency: request at edge N, WAIT during N..N+1, ack sampled at edge N+1, DONE at N+1, IDLE at N+2.
  - mem_addr, mem_wdata and mem_we stay stable for the whole of WAIT, whatever the CPU inputs do.
- DONE (state=000, one cycle):
  - rdata_valid=1 for reads; it stays 0 for writes.
  - CPU requests seen in this cycle are ignored; the CPU is advancing past the completed access.
  - Next state is always IDLE.
- ERR (state=101, one cycle): reached only on timeout; next state is always IDLE.
- rdata holds its value until the next completed read.
- mem_ack while not in WAIT is ignored, with no state or data change.
- rst asserted during WAIT aborts the access: mem_req drops immediately, and a late ack is ignored.
- Back-to-back accesses: at most one access per 3 cycles. A new request is accepted in IDLE only.

Optional Feature:
- Macro: MEMCTL_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYC with no ack, mem_req drops and the FSM goes to ERR. The access is dropped and rdata is unchanged.
  - Ack in the same cycle as expiry wins: the access completes normally.
- Undefined: no counter or ERR state; WAIT lasts until mem_ack. state never shows 101.

Decomposition:
- Shared package (cpu_pkg): status code constants ST_FREE=3'b000, ST_STALL=3'b111, ST_ERR=3'b101, plus the FSM state encoding typedef. The freeze logic imports the same status constants.
- Optional sub-module mem_timeout_cnt (counter with clear/enable/expire), instantiated only under MEMCTL_TIMEOUT_EN. Everything else stays flat.

Test Plan:
- Reset and IDLE:
  - Stimulus: rst=0 mid-WAIT with mem_req=1, then release rst.
  - Required: mem_req=0 and state=000 asynchronously. An ack arriving 2 cycles later is ignored; rdata stays 0.
- Read with 3-cycle memory latency:
  - Stimulus: rd_en with addr=0x100; ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF.
  - Required: state=111 for 3 cycles, then 000. rdata=0xDEADBEEF with rdata_valid pulsed for exactly 1 cycle.
- Write with changing inputs:
  - Stimulus: wr_en with addr=0x20, wdata=0x55AA; the CPU changes addr/wdata during WAIT.
  - Required: mem_addr=0x20, mem_wdata=0x55AA and mem_we=1 held until ack. rdata_valid stays 0.
- Simultaneous rd_en=wr_en=1: the access is a write, mem_we=1. Spurious mem_ack in IDLE causes no state change.
- Zero-wait ack: ack in the first WAIT cycle; DONE on the next edge, back in IDLE 2 cycles after acceptance.
- MEMCTL_TIMEOUT_EN with TIMEOUT_CYC=4, no ack:
  - Required: state=101 for 1 cycle after 4 WAIT cycles, then 000. Repeat the run with ack on the 4th cycle: the access completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: status codes seen by the freeze logic
// and the state encoding of the data-memory access controller.
package cpu_pkg;

    // Status codes published to the pipeline freeze logic.
    // FREE lets the pipeline advance, STALL holds it, and any
    // other code leaves the previous freeze decision in place.
    localparam logic [2:0] ST_FREE  = 3'b000;
    localparam logic [2:0] ST_STALL = 3'b111;
    localparam logic [2:0] ST_ERR   = 3'b101;

    // Access controller FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// WAIT-cycle watchdog for mem_access_ctrl.
// Ports: clk, rst (async, active-low), clr (restart count), en (count
// this cycle), expire (this counted cycle is the LIMIT-th one).
module mem_timeout_cnt #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The count holds the number of WAIT edges already taken, so the
    // edge that would bring it to LIMIT is the expiring one.
    assign expire = en && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: one CPU read/write at a time over a
// req/ack memory handshake, with a 3-bit status for the freeze logic.
// Ports: clk, rst (async, active-low); CPU side rd_en, wr_en, addr,
// wdata, rdata, rdata_valid, state; memory side mem_req, mem_we,
// mem_addr, mem_wdata, mem_ack, mem_rdata.
// Build option: define MEMCTL_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles without ack (state shows ST_ERR for one cycle).
module mem_access_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic [2:0]        state,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    mac_state_t st;
    logic       accept;
    logic       timeout_hit;

    assign accept = (st == S_IDLE) && (rd_en || wr_en);

`ifdef MEMCTL_TIMEOUT_EN
    mem_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC),
        .CNT_W (CNT_W)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (st == S_WAIT),
        .expire (timeout_hit)
    );
`else
    // No watchdog: WAIT lasts until ack and the ERR path is dead.
    assign timeout_hit = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYC[0], CNT_W[0]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= S_IDLE;
            state       <= ST_FREE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (accept) begin
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        // A write wins when both enables are high.
                        mem_we    <= wr_en;
                        mem_req   <= 1'b1;
                        state     <= ST_STALL;
                        st        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Ack beats a timeout expiring on the same edge.
                    if (mem_ack) begin
                        if (!mem_we) begin
                            rdata       <= mem_rdata;
                            rdata_valid <= 1'b1;
                        end
                        mem_req <= 1'b0;
                        state   <= ST_FREE;
                        st      <= S_DONE;
                    end else if (timeout_hit) begin
                        mem_req <= 1'b0;
                        state   <= ST_ERR;
                        st      <= S_ERR;
                    end
                end
                S_DONE: begin
                    // CPU requests here belong to the completed access.
                    state <= ST_FREE;
                    st    <= S_IDLE;
                end
                S_ERR: begin
                    state <= ST_FREE;
                    st    <= S_IDLE;
                end
                default: begin
                    state   <= ST_FREE;
                    mem_req <= 1'b0;
                    st      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
